// File: rtl/mlblock_cfg_pkg.sv
// mlblock_cfg_pkg
//   Shared definitions for the MLBlock_2Dflex configuration loader and the
//   software image builder that produces its scan-chain words.
//
//   Scan-chain image layout (MSB shifted first, so MSB lands at the chain tail):
//     [CFG_IMAGE_W-1 -: CFG_I_D_HALF_W]   I_D_HALF input mux select bits
//     next CFG_RES_D_CNTL_W bits          RES_D_CNTL depth bits, stage 0
//     next CFG_RES_D_CNTL_W bits          RES_D_CNTL depth bits, stage 1
//   The default image is 4 + 2*6 = 16 bits.
package mlblock_cfg_pkg;

    localparam int CFG_STATES = 3;

    typedef enum logic [$clog2(CFG_STATES)-1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

    localparam int CFG_N_STAGES     = 2;
    localparam int CFG_I_D_HALF_W   = 4;
    localparam int CFG_RES_D_CNTL_W = 6;
    localparam int CFG_IMAGE_W      = CFG_I_D_HALF_W + CFG_N_STAGES * CFG_RES_D_CNTL_W;
    localparam int CFG_MODE_W       = 2;

endpackage

// File: rtl/mlblock_config_loader_if.sv
// mlblock_config_loader_if
//   Valid/ready config-word channel into the loader.
//   cfg_valid  : source offers a word
//   cfg_ready  : loader idle; word taken when cfg_valid && cfg_ready
//   cfg_bits   : scan-chain image, MSB shifted first
//   cfg_mode   : tile mode committed after the shift
//   cfg_hp_en  : high-precision enable committed after the shift
interface mlblock_config_loader_if
    import mlblock_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = CFG_IMAGE_W,
    parameter int MODE_W    = CFG_MODE_W
) ();

    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CHAIN_LEN-1:0] cfg_bits;
    logic [MODE_W-1:0]    cfg_mode;
    logic                 cfg_hp_en;

    modport master (
        output cfg_valid, cfg_bits, cfg_mode, cfg_hp_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_bits, cfg_mode, cfg_hp_en,
        output cfg_ready
    );

endinterface

// File: rtl/cfg_piso_siso.sv
// cfg_piso_siso
//   Parallel-load shift-out register paired with a serial-in capture register.
//   clk, reset : clock and asynchronous active-low reset
//   load_i     : load par_i into the shift-out register
//   shift_i    : shift both registers by one bit
//   par_i      : parallel image to shift out, MSB first
//   ser_o      : current MSB of the shift-out register
//   ser_i      : serial bit captured into the LSB of the capture register
//   cap_o      : captured image, first-captured bit at the MSB
module cfg_piso_siso #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] par_i,
    output logic             ser_o,
    input  logic             ser_i,
    output logic [WIDTH-1:0] cap_o
);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] cap_shifted;

    // A one-bit chain has no history to keep, so the capture is just the new bit.
    if (WIDTH == 1) begin : g_cap_single
        assign cap_shifted = ser_i;
    end else begin : g_cap_multi
        assign cap_shifted = {cap_q[WIDTH-2:0], ser_i};
    end

    always_comb begin
        sh_d  = sh_q;
        cap_d = cap_q;
        if (load_i) begin
            sh_d = par_i;
        end else if (shift_i) begin
            sh_d  = sh_q << 1;
            cap_d = cap_shifted;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh_q  <= '0;
            cap_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cap_q <= cap_d;
        end
    end

    assign ser_o = sh_q[WIDTH-1];
    assign cap_o = cap_q;

endmodule

// File: rtl/mlblock_config_loader.sv
// mlblock_config_loader
//   Serialises one config word per handshake into an MLBlock_2Dflex scan chain,
//   captures the previous chain image returning on config_out_i, then commits
//   the tile mode and hp_en together once the shift is complete.
//   clk, reset       : clock and asynchronous active-low reset
//   cfg              : valid/ready config-word channel (slave side)
//   config_en_o      : chain shift enable
//   config_in_o      : serial bit into the chain head
//   config_out_i     : serial bit from the chain tail
//   configg_o        : committed tile mode
//   hp_en_o          : committed high-precision enable
//   compute_hold_o   : high while the chain is in flux
//   rb_valid_o       : one-cycle pulse when rb_bits_o is updated
//   rb_bits_o        : previous chain image, same bit order as cfg_bits
module mlblock_config_loader
    import mlblock_cfg_pkg::*;
#(
    parameter int CHAIN_LEN        = CFG_IMAGE_W,
    parameter int N_OF_COFIGS_LOG2 = CFG_MODE_W
) (
    input  logic                        clk,
    input  logic                        reset,
    mlblock_config_loader_if.slave      cfg,
    output logic                        config_en_o,
    output logic                        config_in_o,
    input  logic                        config_out_i,
    output logic [N_OF_COFIGS_LOG2-1:0] configg_o,
    output logic                        hp_en_o,
    output logic                        compute_hold_o,
    output logic                        rb_valid_o,
    output logic [CHAIN_LEN-1:0]        rb_bits_o
);

    localparam int              CNT_W    = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    cfg_state_t                  state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [N_OF_COFIGS_LOG2-1:0] mode_pend_q;
    logic                        hp_pend_q;
    logic [N_OF_COFIGS_LOG2-1:0] configg_q;
    logic                        hp_en_q;
    logic                        rb_valid_q;
    logic [CHAIN_LEN-1:0]        rb_bits_q;

    logic                        accept;
    logic                        shifting;
    logic                        ser_out;
    logic [CHAIN_LEN-1:0]        cap_image;

    assign accept   = cfg.cfg_valid && (state_q == IDLE);
    assign shifting = (state_q == SHIFT);

    cfg_piso_siso #(
        .WIDTH (CHAIN_LEN)
    ) u_piso_siso (
        .clk     (clk),
        .reset   (reset),
        .load_i  (accept),
        .shift_i (shifting),
        .par_i   (cfg.cfg_bits),
        .ser_o   (ser_out),
        .ser_i   (config_out_i),
        .cap_o   (cap_image)
    );

    // Mode and hp_en are held in pending registers during the shift so the tile
    // never sees a new mode while its chain still holds a half-written image.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_pend_q <= '0;
            hp_pend_q   <= 1'b0;
            configg_q   <= '0;
            hp_en_q     <= 1'b0;
            rb_valid_q  <= 1'b0;
            rb_bits_q   <= '0;
        end else begin
            rb_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cfg.cfg_valid) begin
                        state_q     <= SHIFT;
                        cnt_q       <= '0;
                        mode_pend_q <= cfg.cfg_mode;
                        hp_pend_q   <= cfg.cfg_hp_en;
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == LAST_CNT) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    configg_q  <= mode_pend_q;
                    hp_en_q    <= hp_pend_q;
                    rb_bits_q  <= cap_image;
                    rb_valid_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Serial data is gated by the state so config_in rests at 0 outside a shift.
    assign cfg.cfg_ready    = (state_q == IDLE);
    assign config_en_o      = shifting;
    assign config_in_o      = shifting & ser_out;
    assign compute_hold_o   = (state_q != IDLE);
    assign configg_o        = configg_q;
    assign hp_en_o          = hp_en_q;
    assign rb_valid_o       = rb_valid_q;
    assign rb_bits_o        = rb_bits_q;

endmodule
